// File: rtl/frame_packet_gen_pkg.sv
// Shared definitions for the frame/packet stream generator: FSM state
// encoding, TDATA field offsets and the beat-payload packing helper.
package frame_packet_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Bit offsets of the payload fields inside the low 64 bits of TDATA
    localparam int FRM_LSB  = 48;
    localparam int PKT_LSB  = 32;
    localparam int BEAT_LSB = 0;

    // Counter pattern the downstream checker expects on every beat
    function automatic logic [63:0] pack_beat(input logic [15:0] frm,
                                              input logic [15:0] pkt,
                                              input logic [31:0] beat);
        logic [63:0] w;
        w = '0;
        w[FRM_LSB  +: 16] = frm;
        w[PKT_LSB  +: 16] = pkt;
        w[BEAT_LSB +: 32] = beat;
        return w;
    endfunction

endpackage

// File: rtl/frame_packet_gen_if.sv
// AXI4-Stream bundle between the generator (master) and the sink (slave).
interface frame_packet_gen_if #(
    parameter int DW = 256
) ();
    logic [DW-1:0] AXIS_TDATA;
    logic          AXIS_TVALID;
    logic          AXIS_TREADY;
    logic          AXIS_TLAST;
    logic          AXIS_TUSER;

    modport master (
        output AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, AXIS_TUSER,
        input  AXIS_TREADY
    );

    modport slave (
        input  AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, AXIS_TUSER,
        output AXIS_TREADY
    );
endinterface

// File: rtl/frame_packet_gen.sv
// Frame generator: on each start pulse emits pp_group packets of packet_size
// beats on an AXI4-Stream master, carrying a frame/packet/beat counter payload.
// The configuration is shadowed at start, so mid-frame changes have no effect.
module frame_packet_gen
    import frame_packet_gen_pkg::*;
#(
    parameter int DW = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] packet_size,
    input  logic [31:0] pp_group,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    output logic [31:0] frame_count,
    frame_packet_gen_if.master axis
);

    state_t      state_q, state_d;
    logic [31:0] psize_q, psize_d;
    logic [31:0] grp_q, grp_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] pkt_q, pkt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    logic        last_beat;
    logic        last_pkt;
    logic        hs;

    // Beat/packet end detection against the shadowed configuration
    always_comb begin
        last_beat = (beat_q == psize_q - 32'd1);
        last_pkt  = (pkt_q  == grp_q   - 32'd1);
        hs        = (state_q == ST_SEND) && axis.AXIS_TREADY;
    end

    // Next-state and counter updates; everything holds unless a case changes it
    always_comb begin
        state_d     = state_q;
        psize_d     = psize_q;
        grp_d       = grp_q;
        beat_d      = beat_q;
        pkt_d       = pkt_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    psize_d = packet_size;
                    grp_d   = pp_group;
                    beat_d  = '0;
                    pkt_d   = '0;
                    state_d = (packet_size == '0 || pp_group == '0) ? ST_ERR : ST_SEND;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (last_beat) begin
                        beat_d = '0;
                        pkt_d  = pkt_q + 32'd1;
                        if (last_pkt) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            ST_DONE: begin
                frame_cnt_d = frame_cnt_q + 32'd1;
                state_d     = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; reset forces IDLE so TVALID drops immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            psize_q     <= '0;
            grp_q       <= '0;
            beat_q      <= '0;
            pkt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            psize_q     <= psize_d;
            grp_q       <= grp_d;
            beat_q      <= beat_d;
            pkt_q       <= pkt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Stream outputs derive only from registers, so they hold steady while stalled
    assign axis.AXIS_TVALID = (state_q == ST_SEND);
    assign axis.AXIS_TLAST  = (state_q == ST_SEND) && last_beat;
    assign axis.AXIS_TUSER  = (state_q == ST_SEND) && (beat_q == '0) && (pkt_q == '0);
    assign axis.AXIS_TDATA  = DW'(pack_beat(frame_cnt_q[15:0], pkt_q[15:0], beat_q));

    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign cfg_err     = (state_q == ST_ERR);
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_frame_packet_gen.sv
// Self-checking bench for frame_packet_gen: directed frame scenarios with
// random TREADY, checked beat by beat against a queue-based expected stream.
module tb_frame_packet_gen;

    localparam int DW = 256;

    logic        clk;
    logic        resetn;
    logic [31:0] packet_size;
    logic [31:0] pp_group;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;
    logic [31:0] frame_count;

    frame_packet_gen_if #(.DW(DW)) axis ();

    frame_packet_gen #(.DW(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .packet_size (packet_size),
        .pp_group    (pp_group),
        .start       (start),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
        .frame_count (frame_count),
        .axis        (axis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t exp_q[$];
    int    passes = 0;
    int    total  = 0;
    int    model_frames = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected beat stream for one frame, straight from the payload rules
    task automatic build_frame(input int p, input int g, input int f);
        beat_t b;
        exp_q.delete();
        for (int pk = 0; pk < g; pk++) begin
            for (int bt = 0; bt < p; bt++) begin
                b.data = '0;
                b.data[63:48] = f[15:0];
                b.data[47:32] = pk[15:0];
                b.data[31:0]  = bt;
                b.last = (bt == p - 1);
                b.user = (pk == 0) && (bt == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    // Run one start pulse. rdy_pct: TREADY probability. mid_hs: after this many
    // handshakes, change config and pulse start. abort_hs: assert reset while
    // this beat index is presented (returns without the end-of-frame checks).
    task automatic run_frame(input int p, input int g, input int rdy_pct,
                             input int mid_hs, input int abort_hs);
        bit is_err;
        int hs, cyc, done_cnt, err_cnt, vseen, first_v, last_hs, done_cyc;
        beat_t e;
        is_err = (p == 0) || (g == 0);
        if (!is_err) build_frame(p, g, model_frames);
        else exp_q.delete();

        @(negedge clk);
        packet_size = p;
        pp_group    = g;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;

        hs = 0; cyc = 0; done_cnt = 0; err_cnt = 0; vseen = 0;
        first_v = -1; last_hs = -1; done_cyc = -1;
        while (cyc < 400) begin
            start = 1'b0;
            if (axis.AXIS_TVALID) begin
                vseen++;
                if (first_v < 0) first_v = cyc;
                chk("busy_while_valid", DW'(busy), DW'(1));
                if (abort_hs >= 0 && hs == abort_hs) begin
                    resetn = 1'b0;
                    #1;
                    chk("abort_tvalid", DW'(axis.AXIS_TVALID), DW'(0));
                    chk("abort_frame_count", DW'(frame_count), DW'(0));
                    chk("abort_busy", DW'(busy), DW'(0));
                    @(negedge clk);
                    resetn = 1'b1;
                    model_frames = 0;
                    exp_q.delete();
                    return;
                end
                if (exp_q.size() == 0) begin
                    chk("extra_beat", DW'(1), DW'(0));
                end else begin
                    e = exp_q[0];
                    chk("tdata", axis.AXIS_TDATA, e.data);
                    chk("tlast", DW'(axis.AXIS_TLAST), DW'(e.last));
                    chk("tuser", DW'(axis.AXIS_TUSER), DW'(e.user));
                end
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cfg_err) err_cnt++;

            axis.AXIS_TREADY = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            if (axis.AXIS_TVALID && axis.AXIS_TREADY) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                hs++;
                last_hs = cyc;
                if (hs == mid_hs) begin
                    packet_size = 9;
                    pp_group    = 7;
                    start       = 1'b1;
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
            @(negedge clk);
            cyc++;
        end

        chk("frame_finished", DW'(done_cyc >= 0), DW'(1));
        chk("beat_count", DW'(hs), DW'(p * g));
        chk("exp_drained", DW'(exp_q.size()), DW'(0));
        chk("frame_done_cycles", DW'(done_cnt), DW'(1));
        chk("cfg_err_cycles", DW'(err_cnt), DW'(is_err ? 1 : 0));
        if (is_err) begin
            chk("err_no_valid", DW'(vseen), DW'(0));
        end else begin
            chk("done_after_last", DW'(done_cyc), DW'(last_hs + 1));
            model_frames++;
            if (rdy_pct >= 100)
                chk("no_bubbles", DW'(last_hs - first_v + 1), DW'(p * g));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("idle_after_frame_valid", DW'(axis.AXIS_TVALID), DW'(0));
            chk("idle_after_frame_busy", DW'(busy), DW'(0));
        end
        chk("frame_count", DW'(frame_count), DW'(model_frames));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        packet_size = '0;
        pp_group = '0;
        axis.AXIS_TREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", DW'(axis.AXIS_TVALID), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_frame_done", DW'(frame_done), DW'(0));
        chk("rst_cfg_err", DW'(cfg_err), DW'(0));
        chk("rst_frame_count", DW'(frame_count), DW'(0));
        chk("rst_tlast", DW'(axis.AXIS_TLAST), DW'(0));
        resetn = 1'b1;
        @(negedge clk);

        run_frame(4, 3, 100, -1, -1);     // back-to-back 12 beats
        run_frame(4, 3, 50, -1, -1);      // random stalls
        run_frame(1, 1, 100, -1, -1);     // single beat, TLAST and TUSER together
        run_frame(0, 5, 100, -1, -1);     // zero packet size
        run_frame(3, 0, 100, -1, -1);     // zero group
        run_frame(4, 3, 60, 4, -1);       // start and config change mid-frame
        run_frame(2 + $urandom_range(3), 1 + $urandom_range(3), 70, -1, -1);
        run_frame(4, 3, 100, -1, 5);      // reset during beat 5
        run_frame(4, 3, 100, -1, -1);     // full frame after reset

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Global bound so the run always ends even if a wait never resolves
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
